// File: rtl/id_hazard_sequencer_pkg.sv
// Shared definitions for the decode-stage hazard sequencer: sequencing states,
// register-specifier width and the hard-wired zero register.
package id_hazard_sequencer_pkg;

    localparam int REG_BITS = 5;
    localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;

    // Wide enough for the largest legal drain length (7 cycles).
    localparam int DRAIN_CNT_BITS = 3;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_RUN         = 2'd0;
    localparam seq_state_t ST_SYS_DRAIN   = 2'd1;
    localparam seq_state_t ST_SYS_NOTIFY  = 2'd2;
    localparam seq_state_t ST_SYS_RELEASE = 2'd3;

endpackage

// File: rtl/id_hazard_sequencer_lu_hazard_detect.sv
// Purely combinational load-use compare between the ID sources and the EXE load
// destination; kept separate so the forwarding unit can reuse it.
module id_hazard_sequencer_lu_hazard_detect #(
    parameter int REG_BITS = 5
) (
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_reg_a,
    input  logic                id_uses_a,
    input  logic [REG_BITS-1:0] id_reg_b,
    input  logic                id_uses_b,
    input  logic [REG_BITS-1:0] exe_write_register,
    input  logic                exe_mem_read,
    input  logic                exe_reg_write,
    output logic                lu_hazard
);

    logic exe_is_load;
    logic match_a;
    logic match_b;

    // A load targeting the zero register never produces a usable value.
    assign exe_is_load = exe_mem_read && exe_reg_write && (exe_write_register != '0);
    assign match_a     = id_uses_a && (id_reg_a == exe_write_register);
    assign match_b     = id_uses_b && (id_reg_b == exe_write_register);
    assign lu_hazard   = id_valid && exe_is_load && (match_a || match_b);

endmodule

// File: rtl/id_hazard_sequencer.sv
// Decode-stage stall/bubble controller: one-cycle load-use stalls plus the
// multi-cycle syscall / LL / SC drain, notify and release sequence.
module id_hazard_sequencer #(
    parameter int SYS_DRAIN_CYCLES = 3,
    parameter int REG_BITS         = id_hazard_sequencer_pkg::REG_BITS,
    parameter int CNT_BITS         = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ID_Valid,
    input  logic [REG_BITS-1:0] ID_RegA,
    input  logic                ID_UsesA,
    input  logic [REG_BITS-1:0] ID_RegB,
    input  logic                ID_UsesB,
    input  logic                ID_Syscall,
    input  logic                ID_NoNotify,
    input  logic [REG_BITS-1:0] EXE_WriteRegister,
    input  logic                EXE_MemRead,
    input  logic                EXE_RegWrite,
    input  logic                Branch_Taken,
    output logic                WANT_FREEZE,
    output logic                Bubble_OUT,
    output logic                Pass_Syscall_OUT,
    output logic                Alt_PC_Enable,
    output logic                SYS,
    output logic [CNT_BITS-1:0] Stall_Count
);

    import id_hazard_sequencer_pkg::*;

    localparam logic [DRAIN_CNT_BITS-1:0] DRAIN_LOAD = DRAIN_CNT_BITS'(SYS_DRAIN_CYCLES - 1);
    localparam logic [DRAIN_CNT_BITS-1:0] DRAIN_ONE  = DRAIN_CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]       STALL_ONE  = CNT_BITS'(1);

    seq_state_t                state_q, state_d;
    logic [DRAIN_CNT_BITS-1:0] drain_cnt_q, drain_cnt_d;
    logic                      no_notify_q, no_notify_d;
    logic [CNT_BITS-1:0]       stall_count_q, stall_count_d;

    logic lu_hazard;
    logic want_freeze;
    logic bubble;
    logic pass_syscall;
    logic sys_pulse;

    id_hazard_sequencer_lu_hazard_detect #(
        .REG_BITS (REG_BITS)
    ) u_lu_hazard_detect (
        .id_valid           (ID_Valid),
        .id_reg_a           (ID_RegA),
        .id_uses_a          (ID_UsesA),
        .id_reg_b           (ID_RegB),
        .id_uses_b          (ID_UsesB),
        .exe_write_register (EXE_WriteRegister),
        .exe_mem_read       (EXE_MemRead),
        .exe_reg_write      (EXE_RegWrite),
        .lu_hazard          (lu_hazard)
    );

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        no_notify_d  = no_notify_q;
        want_freeze  = 1'b0;
        bubble       = 1'b0;
        pass_syscall = 1'b0;
        sys_pulse    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Syscall outranks a load-use hazard; the hazard resolves itself
                // because the bubble we send lands in EXE next cycle.
                if (ID_Valid && ID_Syscall) begin
                    want_freeze  = 1'b1;
                    bubble       = 1'b1;
                    pass_syscall = 1'b1;
                    no_notify_d  = ID_NoNotify;
                    drain_cnt_d  = DRAIN_LOAD;
                    state_d      = ST_SYS_DRAIN;
                end else if (lu_hazard) begin
                    want_freeze = 1'b1;
                    bubble      = 1'b1;
                end
            end
            ST_SYS_DRAIN: begin
                want_freeze = 1'b1;
                bubble      = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = ST_SYS_NOTIFY;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                end
            end
            ST_SYS_NOTIFY: begin
                want_freeze = 1'b1;
                bubble      = 1'b1;
                sys_pulse   = !no_notify_q;
                state_d     = ST_SYS_RELEASE;
            end
            ST_SYS_RELEASE: begin
                // Fetch moves on, but the syscall still in ID must not reissue.
                bubble  = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (want_freeze && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            no_notify_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            no_notify_q   <= no_notify_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign WANT_FREEZE      = want_freeze;
    assign Bubble_OUT       = bubble;
    assign Pass_Syscall_OUT = pass_syscall;
    assign SYS              = sys_pulse;
    assign Alt_PC_Enable    = Branch_Taken && !bubble;
    assign Stall_Count      = stall_count_q;

endmodule

// File: tb/tb_id_hazard_sequencer.sv
// Self-checking bench for id_hazard_sequencer: vector table, hand-written
// syscall/reset sequences and randomized traffic against a cycle-position model.
module tb_id_hazard_sequencer;

    localparam int D  = 3;
    localparam int RB = 5;
    localparam int CB = 16;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [RB-1:0] id_reg_a;
    logic          id_uses_a;
    logic [RB-1:0] id_reg_b;
    logic          id_uses_b;
    logic          id_syscall;
    logic          id_no_notify;
    logic [RB-1:0] exe_wr;
    logic          exe_mem_read;
    logic          exe_reg_write;
    logic          branch_taken;
    logic          want_freeze;
    logic          bubble_out;
    logic          pass_syscall;
    logic          alt_pc_enable;
    logic          sys;
    logic [CB-1:0] stall_count;

    int n_vectors;
    int n_miscompares;
    int exp_stall;

    id_hazard_sequencer #(
        .SYS_DRAIN_CYCLES (D),
        .REG_BITS         (RB),
        .CNT_BITS         (CB)
    ) dut (
        .CLK               (clk),
        .RESET             (rst),
        .ID_Valid          (id_valid),
        .ID_RegA           (id_reg_a),
        .ID_UsesA          (id_uses_a),
        .ID_RegB           (id_reg_b),
        .ID_UsesB          (id_uses_b),
        .ID_Syscall        (id_syscall),
        .ID_NoNotify       (id_no_notify),
        .EXE_WriteRegister (exe_wr),
        .EXE_MemRead       (exe_mem_read),
        .EXE_RegWrite      (exe_reg_write),
        .Branch_Taken      (branch_taken),
        .WANT_FREEZE       (want_freeze),
        .Bubble_OUT        (bubble_out),
        .Pass_Syscall_OUT  (pass_syscall),
        .Alt_PC_Enable     (alt_pc_enable),
        .SYS               (sys),
        .Stall_Count       (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [RB-1:0] reg_a;
        logic          uses_a;
        logic [RB-1:0] reg_b;
        logic          uses_b;
        logic [RB-1:0] wr;
        logic          mem_read;
        logic          reg_write;
        logic          branch;
        logic          e_freeze;
        logic          e_bubble;
        logic          e_alt;
    } vec_t;

    vec_t tbl [12];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [RB-1:0] ra, input logic ua,
                                  input logic [RB-1:0] rb, input logic ub, input logic sc,
                                  input logic nn, input logic [RB-1:0] wr, input logic mr,
                                  input logic rw, input logic br);
        id_valid      = v;
        id_reg_a      = ra;
        id_uses_a     = ua;
        id_reg_b      = rb;
        id_uses_b     = ub;
        id_syscall    = sc;
        id_no_notify  = nn;
        exe_wr        = wr;
        exe_mem_read  = mr;
        exe_reg_write = rw;
        branch_taken  = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every output of the current cycle against the given expectations and
    // then accounts the cycle in the expected stall count.
    task automatic check_cycle(input string tag, input logic f, input logic b, input logic p,
                               input logic s, input logic a);
        check_output({tag, ".freeze"}, 32'(want_freeze), 32'(f));
        check_output({tag, ".bubble"}, 32'(bubble_out), 32'(b));
        check_output({tag, ".pass"},   32'(pass_syscall), 32'(p));
        check_output({tag, ".sys"},    32'(sys), 32'(s));
        check_output({tag, ".alt"},    32'(alt_pc_enable), 32'(a));
        check_output({tag, ".stall"},  32'(stall_count), 32'(exp_stall));
        if (f && exp_stall != 32'hFFFF) exp_stall++;
    endtask

    // Full syscall sequence with a matching load and a taken branch held in the
    // inputs to show both are ignored while the sequence runs.
    task automatic run_sys(input logic nn);
        for (int c = 1; c <= 7; c++) begin
            apply_stimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, (c <= 6), nn, 5'd3, (c <= 6), 1'b1, 1'b1);
            #4;
            check_cycle($sformatf("sys_nn%0d_c%0d", nn, c),
                        (c <= D + 2), (c <= D + 3), (c == 1), (c == D + 2) && !nn, (c == 7));
            tick();
        end
    endtask

    initial begin
        int  pos;
        logic nn_m;

        n_vectors     = 0;
        n_miscompares = 0;
        exp_stall     = 0;

        //                valid ra   ua   rb   ub   wr   mr   rw   br   F    B    A
        tbl[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'd1, 1'b0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 5'd9, 1'b1, 5'd4, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 5'd9, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        #4;
        check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(tbl[i].valid, tbl[i].reg_a, tbl[i].uses_a, tbl[i].reg_b, tbl[i].uses_b,
                           1'b0, 1'b0, tbl[i].wr, tbl[i].mem_read, tbl[i].reg_write, tbl[i].branch);
            #4;
            check_cycle($sformatf("tbl%0d", i), tbl[i].e_freeze, tbl[i].e_bubble, 1'b0, 1'b0, tbl[i].e_alt);
            tick();
        end

        run_sys(1'b0);
        run_sys(1'b1);

        // Reset lands while the drain counter holds 1; nothing of the sequence survives.
        apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #4;
        check_cycle("abort_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #4;
        check_cycle("abort_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        exp_stall = 0;
        #4;
        check_cycle("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #4;
            check_cycle($sformatf("abort_after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        run_sys(1'b0);

        // Randomized traffic: the model tracks the position within a syscall
        // sequence (0 = none) and derives every output from that position.
        pos  = 0;
        nn_m = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic          v, ua, ub, sc, nn, mr, rw, br, lu;
            logic          f, b, p, s;
            logic [RB-1:0] ra, rbr, wr;
            v   = ($urandom_range(0, 9) < 8);
            ra  = RB'($urandom_range(0, 3));
            rbr = RB'($urandom_range(0, 3));
            wr  = RB'($urandom_range(0, 3));
            ua  = 1'($urandom);
            ub  = 1'($urandom);
            sc  = ($urandom_range(0, 11) == 0);
            nn  = 1'($urandom);
            mr  = ($urandom_range(0, 9) < 7);
            rw  = ($urandom_range(0, 9) < 7);
            br  = 1'($urandom);
            apply_stimulus(v, ra, ua, rbr, ub, sc, nn, wr, mr, rw, br);
            #4;
            lu = v && mr && rw && (wr != 0) && ((ua && ra == wr) || (ub && rbr == wr));
            f = 1'b0; b = 1'b0; p = 1'b0; s = 1'b0;
            if (pos == 0) begin
                if (v && sc) begin
                    f = 1'b1; b = 1'b1; p = 1'b1;
                end else if (lu) begin
                    f = 1'b1; b = 1'b1;
                end
            end else begin
                f = (pos <= D + 2);
                b = 1'b1;
                s = (pos == D + 2) && !nn_m;
            end
            check_cycle($sformatf("rand%0d", n), f, b, p, s, br && !b);
            if (pos == 0) begin
                if (v && sc) begin
                    pos  = 2;
                    nn_m = nn;
                end
            end else if (pos == D + 3) begin
                pos = 0;
            end else begin
                pos++;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/id_hazard_sequencer.md
Name: id_hazard_sequencer

Overview:
Central stall/bubble controller for the decode stage. It detects load-use hazards between the instruction in ID and the load in EXE, and sequences the multi-cycle syscall/LL/SC drain. It also gates branch/jump redirects while ID is stalled. Fetch, ID and the simulator interface all consume its outputs, so all freeze/bubble decisions live in one FSM instead of being spread across ID.

Parameters:
SYS_DRAIN_CYCLES, 3, cycles spent in SYS_DRAIN before the notify cycle; legal range 1..7
REG_BITS, 5, register-specifier width
CNT_BITS, 16, width of the saturating stall counter

Ports:
CLK  in  1  pipeline clock; all state updates on the rising edge
RESET  in  1  asynchronous, active-high reset
ID_Valid  in  1  ID holds a real instruction; 0 means the stage holds a NOP
ID_RegA  in  REG_BITS  rs specifier of the ID instruction
ID_UsesA  in  1  ID instruction reads ID_RegA
ID_RegB  in  REG_BITS  rt specifier of the ID instruction
ID_UsesB  in  1  ID instruction reads ID_RegB
ID_Syscall  in  1  decoder syscall flag (also set for LL/SC)
ID_NoNotify  in  1  the syscall-class instruction is LL/SC: drain only, no SYS pulse
EXE_WriteRegister  in  REG_BITS  destination register of the instruction in EXE
EXE_MemRead  in  1  the EXE instruction is a load
EXE_RegWrite  in  1  the EXE instruction writes a register
Branch_Taken  in  1  ID compare unit requests the alternate PC
WANT_FREEZE  out  1  fetch holds its PC and instruction
Bubble_OUT  out  1  ID drives NOP control fields into EXE this cycle
Pass_Syscall_OUT  out  1  ID forwards the syscall opcode and ALU control with the bubble, so MEM flushes
Alt_PC_Enable  out  1  Branch_Taken qualified by the absence of a bubble
SYS  out  1  one-cycle pulse telling the simulator to service a syscall
Stall_Count  out  CNT_BITS  number of cycles with WANT_FREEZE=1, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is CLK, reset port is RESET.
- Reset: FSM goes to RUN, drain counter to 0, latched no-notify flag to 0, Stall_Count to 0. In RUN, with ID_Valid=0 and no hazard, every output is 0.
- The FSM state is registered. Outputs are combinational from state and current inputs.
- Load-use hazard (LU) = ID_Valid & EXE_MemRead & EXE_RegWrite & EXE_WriteRegister != 0 & ((ID_UsesA & ID_RegA == EXE_WriteRegister) | (ID_UsesB & ID_RegB == EXE_WriteRegister)).
- RUN:
  - If ID_Valid & ID_Syscall: WANT_FREEZE=1, Bubble_OUT=1, Pass_Syscall_OUT=1. Latch nn = ID_NoNotify. Load cnt = SYS_DRAIN_CYCLES-1. Next state SYS_DRAIN.
  - Else if LU: WANT_FREEZE=1, Bubble_OUT=1, stay in RUN. The next cycle EXE holds a bubble, so LU clears by construction and the instruction issues. Stall is exactly 1 cycle.
  - Else: all control outputs 0.
  - Syscall has priority over LU when both are true.
- SYS_DRAIN: WANT_FREEZE=1, Bubble_OUT=1, Pass_Syscall_OUT=0. If cnt==0, next state SYS_NOTIFY; else cnt-1.
- SYS_NOTIFY: WANT_FREEZE=1, Bubble_OUT=1, SYS=!nn. Next state SYS_RELEASE.
- SYS_RELEASE: WANT_FREEZE=0 (fetch advances), Bubble_OUT=1 (the syscall must not reissue). ID_Syscall is ignored. Next state RUN.
- Latency: syscall seen in RUN at cycle t gives SYS high at t+SYS_DRAIN_CYCLES+1 and WANT_FREEZE low at t+SYS_DRAIN_CYCLES+2.
- Back-to-back syscalls: a syscall arriving in RUN the cycle after SYS_RELEASE starts a fresh sequence. There is no overlap.
- Alt_PC_Enable = Branch_Taken & !Bubble_OUT in every state. A redirect is never issued from a stalled or bubbled instruction.
- Stall_Count increments each cycle WANT_FREEZE=1. It holds at all-ones.
- Reset asserted mid-sequence aborts immediately, with no SYS pulse. Deassertion resumes in RUN.
- Input changes during SYS_DRAIN/SYS_NOTIFY (hazard, branch) have no effect apart from the Alt_PC_Enable masking.

Decomposition:
- Shared package holds the state enum {RUN, SYS_DRAIN, SYS_NOTIFY, SYS_RELEASE} (2 bits), REG_ZERO = 5'd0, and REG_BITS.
- One natural sub-module, lu_hazard_detect: the purely combinational LU compare. It can be reused by the forwarding unit.
- The FSM, drain counter and stall counter stay in the top module.

Test Plan:
- LU on rs: EXE lw to r8 (MemRead=1, RegWrite=1, WR=8); ID add with RegA=8, UsesA=1 -> WANT_FREEZE=1 and Bubble_OUT=1 for exactly 1 cycle, Stall_Count=1. Next cycle EXE holds the NOP and all outputs are 0.
- LU false cases -> no stall for each of: EXE_WriteRegister=0; ID_UsesB=0 with RegB match; EXE_MemRead=0 with a matching register.
- Syscall, SYS_DRAIN_CYCLES=3, ID_NoNotify=0 -> 5 frozen cycles, SYS pulsed on cycle 5 only, Pass_Syscall_OUT on cycle 1 only, WANT_FREEZE=0 with Bubble_OUT=1 on cycle 6, RUN on cycle 7, Stall_Count=5.
- LL with ID_NoNotify=1 -> same timing, SYS never asserted.
- Branch_Taken=1 coincident with LU -> Alt_PC_Enable=0 that cycle; the next cycle, without LU, gives Alt_PC_Enable=1.
- RESET pulsed during SYS_DRAIN (cnt=1) -> all outputs 0 immediately, no SYS pulse. A new syscall after release restarts the full 5-cycle freeze.
